vp_decoder: RTL and testbench
=============================

Name: vp_decoder

Overview:
- Consumer side of the sparse weight/activation ping-pong encoder interface.
- Captures each filled 3-entry buffer (right, then left, alternating) when the encoder flags it ready.
- Drops zero-weight padding entries and forms signed weight×activation products.
- Streams (address, product) pairs to the downstream accumulator over a valid/ready handshake, then signals completion after the encoder's finish.

Parameters:
- ADDR_W, 7, width of one address field (address = 3 fields, 3*ADDR_W bits)
- DATA_W, 16, signed weight/activation width
- PROD_W, 32, signed product width (2*DATA_W)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_start  in  1  run enable; low while idle clears sticky flags
- i_right_ready  in  1  encoder right-buffer ready level
- i_left_ready  in  1  encoder left-buffer ready level
- i_addr_right_buffer[0:2]  in  3*ADDR_W each  right buffer addresses
- i_w_data_right_buffer[0:2]  in  DATA_W signed  right weights
- i_ia_data_right_buffer[0:2]  in  DATA_W signed  right activations
- i_addr_left_buffer[0:2], i_w_data_left_buffer[0:2], i_ia_data_left_buffer[0:2]  in  same  left buffer
- i_enc_finish  in  1  encoder finish level
- o_valid  out  1  output pair valid
- i_out_ready  in  1  downstream accept
- o_addr  out  3*ADDR_W  address of product
- o_product  out  PROD_W signed  w*ia
- o_busy  out  1  FSM not in S_IDLE
- o_overflow  out  1  sticky: buffer ready edge arrived while that slot still held undrained data
- o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): all outputs 0; both slots empty; FSM S_IDLE; expected slot = RIGHT; edge-detect registers 0. Reset mid-operation discards all captured data and in-flight output.
- Edge detect: ready and finish inputs are registered. A capture occurs on a 0→1 transition. A level held high never re-captures.
- Capture: on a right rising edge, copy all 3 right entries into slot R and set full_R. The left side is the same into slot L. Both edges in the same cycle capture both.
  - If the slot is full and is not being freed in that cycle, the capture is dropped and o_overflow is set (sticky).
  - A slot freed in the same cycle as a new edge accepts the capture.
- Drain order: strictly R, L, R, L… starting at R. Entries within a slot go index 0..2.
- FSM states:
  - S_IDLE: on i_start=1 → S_DRAIN. i_start=0 clears o_overflow.
  - S_DRAIN: each cycle where the expected slot is full and the output register is free or being accepted, examine the current entry.
    - w==0: skip, no output, index advances.
    - else: load o_addr and o_product = w*ia (full-precision signed), assert o_valid, index advance.
    - At index 2 the slot is cleared, index resets to 0, and the expected slot toggles.
  - S_DRAIN also watches finish: a finish rising edge sets finish_seen. When finish_seen, both slots are empty and the output register is empty → S_DONE.
  - S_DONE: assert o_done for 1 cycle; clear finish_seen; reset expected slot to RIGHT → S_IDLE.
- Output handshake: o_valid, o_addr and o_product are held stable until i_out_ready=1 while o_valid=1. Backpressure stalls draining and does not stall capture.
- Latency: ready edge at encoder output cycle N → slot full at N+2 (edge register plus capture) → first o_valid at N+3 with no backpressure. Throughput is 1 pair/cycle.
- An all-zero-weight slot produces no outputs and consumes 3 cycles.
- A finish edge while a slot is being captured in the same cycle: the capture completes first, and completion waits for that slot to drain.

Decomposition:
- Shared package: ADDR_W, DATA_W, PROD_W; a buffer-entry struct typedef (addr, w, ia); a slot enum (SLOT_R, SLOT_L); FSM state enum.
- One natural sub-module: vp_out_stage, a 1-entry valid/ready output register with multiply-on-load.

Test Plan:
- Full right buffer {w=2,ia=3},{w=-4,ia=5},{w=7,ia=-1} with addrs A0..A2, i_out_ready=1 → outputs 6, -20, -7 in order with matching addrs on 3 consecutive cycles. The first o_valid comes 3 cycles after the ready edge.
- Right buffer {5,1},{0,0},{0,0}, then finish → exactly one output of 5, then o_done pulse 1 cycle, o_busy falls next cycle.
- Right then left buffers back-to-back, i_out_ready toggling 1/0 every cycle → 6 outputs in R-then-L order, each held stable while stalled, no overflow.
- Second right ready edge before slot R drains (i_out_ready=0) → o_overflow=1 and stays 1 until i_start=0 in S_IDLE. The original data is output intact.
- Extreme values w=-32768, ia=-32768 → o_product=+1073741824 with no truncation.
- Assert i_rst_n=0 mid-drain with o_valid=1 → o_valid, o_busy and o_done are 0 immediately. After release, a new run starts from slot R.

Source files
------------

// File: rtl/vp_decoder_pkg.sv
// Shared widths, buffer-entry layout, slot tags and FSM encodings for the
// sparse ping-pong decoder.
package vp_decoder_pkg;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 16;
   localparam int PROD_W  = 32;
   localparam int AFULL_W = 3 * ADDR_W;

   typedef struct packed {
      logic [AFULL_W-1:0] addr;
      logic [DATA_W-1:0]  w;
      logic [DATA_W-1:0]  ia;
   } entry_t;

   typedef enum logic {
      SLOT_R = 1'b0,
      SLOT_L = 1'b1
   } slot_t;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/vp_out_stage.sv
// Single-entry valid/ready output register; the signed product is formed
// as the entry is loaded.
module vp_out_stage
   import vp_decoder_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [AFULL_W-1:0]       in_addr,
   input  logic signed [DATA_W-1:0] in_w,
   input  logic signed [DATA_W-1:0] in_ia,
   input  logic                     ready,
   output logic                     valid,
   output logic [AFULL_W-1:0]       addr,
   output logic signed [PROD_W-1:0] product,
   output logic                     free
);
   logic signed [PROD_W-1:0] prod_c;

   // Sign-extend both operands to the full product width before multiplying.
   assign prod_c = PROD_W'(in_w) * PROD_W'(in_ia);
   assign free   = ~valid | ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         addr    <= '0;
         product <= '0;
      end else if (load) begin
         valid   <= 1'b1;
         addr    <= in_addr;
         product <= prod_c;
      end else if (ready) begin
         valid   <= 1'b0;
      end
   end
endmodule

// File: rtl/vp_decoder.sv
// Consumer of the encoder's right/left 3-entry buffers: captures on ready
// edges, drains R,L,R,... skipping zero weights, streams (addr, w*ia) pairs.
module vp_decoder
   import vp_decoder_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_right_ready,
   input  logic                     i_left_ready,
   input  logic [AFULL_W-1:0]       i_addr_right_buffer    [0:2],
   input  logic signed [DATA_W-1:0] i_w_data_right_buffer  [0:2],
   input  logic signed [DATA_W-1:0] i_ia_data_right_buffer [0:2],
   input  logic [AFULL_W-1:0]       i_addr_left_buffer     [0:2],
   input  logic signed [DATA_W-1:0] i_w_data_left_buffer   [0:2],
   input  logic signed [DATA_W-1:0] i_ia_data_left_buffer  [0:2],
   input  logic                     i_enc_finish,
   output logic                     o_valid,
   input  logic                     i_out_ready,
   output logic [AFULL_W-1:0]       o_addr,
   output logic signed [PROD_W-1:0] o_product,
   output logic                     o_busy,
   output logic                     o_overflow,
   output logic                     o_done,
   output logic [1:0]               o_state
);
   // Handshake: a pair transfers on a clock edge where o_valid and
   // i_out_ready are both high; until then o_valid/o_addr/o_product hold.
   logic [1:0] state, state_nx;
   entry_t     slot_r [0:2];
   entry_t     slot_l [0:2];
   logic       full_r, full_l;
   slot_t      exp_slot;
   logic [1:0] idx;
   logic       finish_seen;
   logic       rdy_r_q, rdy_r_q2, rdy_l_q, rdy_l_q2, fin_q, fin_q2;

   logic       edge_r, edge_l, edge_f;
   entry_t     cur;
   logic       cur_full, out_free, step, load, last;
   logic       free_r, free_l, take_r, take_l, ovf_set, done_cond;

   assign edge_r = rdy_r_q & ~rdy_r_q2;
   assign edge_l = rdy_l_q & ~rdy_l_q2;
   assign edge_f = fin_q & ~fin_q2;

   assign cur      = (exp_slot == SLOT_R) ? slot_r[idx] : slot_l[idx];
   assign cur_full = (exp_slot == SLOT_R) ? full_r : full_l;
   assign step     = (state == S_DRAIN) && cur_full && out_free;
   assign load     = step && (cur.w != '0);
   assign last     = step && (idx == 2'd2);
   assign free_r   = last && (exp_slot == SLOT_R);
   assign free_l   = last && (exp_slot == SLOT_L);

   // A slot emptied on this edge can take the new buffer immediately.
   assign take_r  = edge_r && (!full_r || free_r);
   assign take_l  = edge_l && (!full_l || free_l);
   assign ovf_set = (edge_r && full_r && !free_r) || (edge_l && full_l && !free_l);

   // Pending captures block completion so a same-cycle finish waits for them.
   assign done_cond = finish_seen && !full_r && !full_l && !o_valid && !edge_r && !edge_l;

   assign o_busy  = (state != S_IDLE);
   assign o_done  = (state == S_DONE);
   assign o_state = state;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (i_start) state_nx = S_DRAIN;
         S_DRAIN: if (done_cond) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_r_q  <= 1'b0;
         rdy_r_q2 <= 1'b0;
         rdy_l_q  <= 1'b0;
         rdy_l_q2 <= 1'b0;
         fin_q    <= 1'b0;
         fin_q2   <= 1'b0;
      end else begin
         rdy_r_q  <= i_right_ready;
         rdy_r_q2 <= rdy_r_q;
         rdy_l_q  <= i_left_ready;
         rdy_l_q2 <= rdy_l_q;
         fin_q    <= i_enc_finish;
         fin_q2   <= fin_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         full_r <= 1'b0;
         full_l <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            slot_r[i] <= '0;
            slot_l[i] <= '0;
         end
      end else begin
         if (take_r) begin
            full_r <= 1'b1;
            for (int i = 0; i < 3; i++)
               slot_r[i] <= '{addr: i_addr_right_buffer[i],
                              w:    i_w_data_right_buffer[i],
                              ia:   i_ia_data_right_buffer[i]};
         end else if (free_r) begin
            full_r <= 1'b0;
         end
         if (take_l) begin
            full_l <= 1'b1;
            for (int i = 0; i < 3; i++)
               slot_l[i] <= '{addr: i_addr_left_buffer[i],
                              w:    i_w_data_left_buffer[i],
                              ia:   i_ia_data_left_buffer[i]};
         end else if (free_l) begin
            full_l <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         exp_slot    <= SLOT_R;
         idx         <= 2'd0;
         finish_seen <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         state <= state_nx;
         if (step)
            idx <= last ? 2'd0 : idx + 2'd1;
         if (last)
            exp_slot <= (exp_slot == SLOT_R) ? SLOT_L : SLOT_R;
         else if (state == S_DONE)
            exp_slot <= SLOT_R;
         if (state == S_DONE)
            finish_seen <= 1'b0;
         else if (state == S_DRAIN && edge_f)
            finish_seen <= 1'b1;
         if (ovf_set)
            o_overflow <= 1'b1;
         else if (state == S_IDLE && !i_start)
            o_overflow <= 1'b0;
      end
   end

   vp_out_stage u_out (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .load    (load),
      .in_addr (cur.addr),
      .in_w    (cur.w),
      .in_ia   (cur.ia),
      .ready   (i_out_ready),
      .valid   (o_valid),
      .addr    (o_addr),
      .product (o_product),
      .free    (out_free)
   );
endmodule

// File: tb/tb_vp_decoder.sv
// Directed bench for vp_decoder: table of buffer entries with hand-computed
// products, plus sequences for latency, stall, overflow, finish and reset.
module tb_vp_decoder;
   import vp_decoder_pkg::*;

   typedef struct {
      logic [AFULL_W-1:0]       addr;
      logic signed [DATA_W-1:0] w;
      logic signed [DATA_W-1:0] ia;
      logic signed [PROD_W-1:0] prod;
      logic                     emit;
   } vec_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     right_ready = 1'b0;
   logic                     left_ready = 1'b0;
   logic [AFULL_W-1:0]       addr_r [0:2];
   logic signed [DATA_W-1:0] w_r    [0:2];
   logic signed [DATA_W-1:0] ia_r   [0:2];
   logic [AFULL_W-1:0]       addr_l [0:2];
   logic signed [DATA_W-1:0] w_l    [0:2];
   logic signed [DATA_W-1:0] ia_l   [0:2];
   logic                     finish = 1'b0;
   logic                     out_ready = 1'b0;
   logic                     o_valid, o_busy, o_overflow, o_done;
   logic [AFULL_W-1:0]       o_addr;
   logic signed [PROD_W-1:0] o_product;
   logic [1:0]               o_state;

   int total = 0;
   int bad = 0;
   int n_xfer = 0;
   vec_t tbl [0:8];
   logic [AFULL_W+PROD_W-1:0] exp_q[$];
   logic                      stall_prev = 1'b0;
   logic [AFULL_W+PROD_W-1:0] held;

   vp_decoder dut (
      .i_clk                  (clk),
      .i_rst_n                (rst_n),
      .i_start                (start),
      .i_right_ready          (right_ready),
      .i_left_ready           (left_ready),
      .i_addr_right_buffer    (addr_r),
      .i_w_data_right_buffer  (w_r),
      .i_ia_data_right_buffer (ia_r),
      .i_addr_left_buffer     (addr_l),
      .i_w_data_left_buffer   (w_l),
      .i_ia_data_left_buffer  (ia_l),
      .i_enc_finish           (finish),
      .o_valid                (o_valid),
      .i_out_ready            (out_ready),
      .o_addr                 (o_addr),
      .o_product              (o_product),
      .o_busy                 (o_busy),
      .o_overflow             (o_overflow),
      .o_done                 (o_done),
      .o_state                (o_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, logic [63:0] got, logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, expv);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", {63'd0, o_valid}, 64'd1);
            check("hold_data", {11'd0, o_addr, o_product}, {11'd0, held});
         end
         if (o_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0)
               check("unexpected_out", {11'd0, o_addr, o_product}, 64'd0);
            else
               check("out_pair", {11'd0, o_addr, o_product}, {11'd0, exp_q.pop_front()});
         end
         stall_prev = o_valid && !out_ready;
         held = {o_addr, o_product};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_right(int base);
      for (int i = 0; i < 3; i++) begin
         addr_r[i] = tbl[base+i].addr;
         w_r[i]    = tbl[base+i].w;
         ia_r[i]   = tbl[base+i].ia;
      end
   endtask

   task automatic load_left(int base);
      for (int i = 0; i < 3; i++) begin
         addr_l[i] = tbl[base+i].addr;
         w_l[i]    = tbl[base+i].w;
         ia_l[i]   = tbl[base+i].ia;
      end
   endtask

   task automatic push_group(int base);
      for (int i = 0; i < 3; i++)
         if (tbl[base+i].emit)
            exp_q.push_back({tbl[base+i].addr, tbl[base+i].prod});
   endtask

   task automatic wait_drain(string name, int budget);
      int n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < budget) begin
         tick();
         n++;
      end
      check(name, {63'd0, (exp_q.size() == 0 && !o_valid)}, 64'd1);
   endtask

   task automatic wait_done(string name, int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         tick();
         n++;
      end
      check(name, {63'd0, o_done}, 64'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int x0;
      tbl[0] = '{addr: 21'h000A01, w:  16'sd2,      ia:  16'sd3,      prod:  32'sd6,          emit: 1'b1};
      tbl[1] = '{addr: 21'h000B02, w: -16'sd4,      ia:  16'sd5,      prod: -32'sd20,         emit: 1'b1};
      tbl[2] = '{addr: 21'h1FFFF0, w:  16'sd7,      ia: -16'sd1,      prod: -32'sd7,          emit: 1'b1};
      tbl[3] = '{addr: 21'h0A0A0A, w: -16'sd32768,  ia: -16'sd32768,  prod:  32'sd1073741824, emit: 1'b1};
      tbl[4] = '{addr: 21'h000055, w:  16'sd0,      ia:  16'sd9,      prod:  32'sd0,          emit: 1'b0};
      tbl[5] = '{addr: 21'h1ABCDE, w:  16'sd32767,  ia: -16'sd32768,  prod: -32'sd1073709056, emit: 1'b1};
      tbl[6] = '{addr: 21'h000033, w:  16'sd5,      ia:  16'sd1,      prod:  32'sd5,          emit: 1'b1};
      tbl[7] = '{addr: 21'h000034, w:  16'sd0,      ia:  16'sd0,      prod:  32'sd0,          emit: 1'b0};
      tbl[8] = '{addr: 21'h000035, w:  16'sd0,      ia:  16'sd0,      prod:  32'sd0,          emit: 1'b0};
      load_right(0);
      load_left(3);

      // Reset state
      tick();
      tick();
      check("rst_valid", {63'd0, o_valid}, 64'd0);
      check("rst_busy", {63'd0, o_busy}, 64'd0);
      check("rst_done", {63'd0, o_done}, 64'd0);
      check("rst_ovf", {63'd0, o_overflow}, 64'd0);
      check("rst_state", {62'd0, o_state}, {62'd0, S_IDLE});
      rst_n = 1'b1;
      tick();

      // Latency and in-order right buffer, then left buffer with a zero skip
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      check("busy_after_start", {63'd0, o_busy}, 64'd1);
      load_right(0);
      push_group(0);
      right_ready = 1'b1;
      tick();
      tick();
      check("lat_early", {63'd0, o_valid}, 64'd0);
      tick();
      check("lat_first", {63'd0, o_valid}, 64'd1);
      tick();
      check("lat_second", {63'd0, o_valid}, 64'd1);
      tick();
      check("lat_third", {63'd0, o_valid}, 64'd1);
      wait_drain("drain_a_right", 20);
      right_ready = 1'b0;
      load_left(3);
      push_group(3);
      left_ready = 1'b1;
      wait_drain("drain_a_left", 20);
      left_ready = 1'b0;
      tick();

      // Back-to-back R then L with toggling downstream ready
      load_right(0);
      load_left(3);
      push_group(0);
      push_group(3);
      right_ready = 1'b1;
      tick();
      left_ready = 1'b1;
      for (int n = 0; n < 80; n++) begin
         out_ready = ~out_ready;
         tick();
         if (exp_q.size() == 0 && !o_valid) break;
      end
      check("drain_b", {63'd0, exp_q.size() == 0}, 64'd1);
      check("ovf_b", {63'd0, o_overflow}, 64'd0);
      out_ready = 1'b1;
      right_ready = 1'b0;
      left_ready = 1'b0;
      tick();

      // Single output with finish arriving with the ready edge
      x0 = n_xfer;
      load_right(6);
      push_group(6);
      right_ready = 1'b1;
      finish = 1'b1;
      start = 1'b0;
      wait_done("done_c", 40);
      check("xfer_c", n_xfer - x0, 64'd1);
      check("busy_in_done", {63'd0, o_busy}, 64'd1);
      tick();
      check("done_pulse", {63'd0, o_done}, 64'd0);
      check("busy_fall", {63'd0, o_busy}, 64'd0);
      finish = 1'b0;
      right_ready = 1'b0;
      tick();

      // Overflow on a second right edge while slot R is stalled
      start = 1'b1;
      out_ready = 1'b0;
      tick();
      load_right(0);
      push_group(0);
      right_ready = 1'b1;
      repeat (4) tick();
      right_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         addr_r[i] = 21'h0;
         w_r[i]    = 16'sd1;
         ia_r[i]   = 16'sd1;
      end
      right_ready = 1'b1;
      repeat (3) tick();
      check("ovf_set", {63'd0, o_overflow}, 64'd1);
      out_ready = 1'b1;
      wait_drain("drain_d", 20);
      check("ovf_sticky", {63'd0, o_overflow}, 64'd1);
      finish = 1'b1;
      start = 1'b0;
      wait_done("done_d", 40);
      tick();
      check("ovf_in_idle", {63'd0, o_overflow}, 64'd1);
      tick();
      check("ovf_cleared", {63'd0, o_overflow}, 64'd0);
      finish = 1'b0;
      right_ready = 1'b0;
      tick();

      // Reset mid-drain, then a fresh run starting from slot R
      start = 1'b1;
      out_ready = 1'b0;
      tick();
      load_right(0);
      push_group(0);
      right_ready = 1'b1;
      for (int n = 0; n < 10 && !o_valid; n++) tick();
      check("valid_before_rst", {63'd0, o_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", {63'd0, o_valid}, 64'd0);
      check("rst_mid_busy", {63'd0, o_busy}, 64'd0);
      check("rst_mid_done", {63'd0, o_done}, 64'd0);
      exp_q.delete();
      right_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      load_right(3);
      load_left(0);
      push_group(3);
      push_group(0);
      out_ready = 1'b1;
      right_ready = 1'b1;
      left_ready = 1'b1;
      wait_drain("drain_e", 30);
      finish = 1'b1;
      wait_done("done_e", 40);
      check("ovf_e", {63'd0, o_overflow}, 64'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
